// File: rtl/arcade_input_hub.sv
// Arcade control front-end: merges PS/2 keyboard and per-player joystick words
// into registered active-low cabinet inputs with coin stretch, autofire, SOCD and pause pulse.
module arcade_input_hub #(
    parameter int PLAYERS      = 2,
    parameter int BUTTONS      = 2,
    parameter int COIN_CYCLES  = 4915200,
    parameter int AF_SHIFT     = 18,
    parameter int SOCD_NEUTRAL = 1
) (
    input  logic                         clk_49m,
    input  logic                         reset,
    input  logic [10:0]                  ps2_key,
    input  logic [16*PLAYERS-1:0]        joy,
    input  logic                         pause_in,
    input  logic [BUTTONS-1:0]           af_en,
    input  logic [1:0]                   af_rate,
    output logic [4*PLAYERS-1:0]         dir_n,
    output logic [BUTTONS*PLAYERS-1:0]   btn_n,
    output logic [PLAYERS-1:0]           start_n,
    output logic [PLAYERS-1:0]           coin_n,
    output logic                         service_n,
    output logic                         pause_pulse
);

    localparam int CW = (COIN_CYCLES < 1) ? 1 : $clog2(COIN_CYCLES + 1);
    localparam int PW = AF_SHIFT + 4;
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES);
    localparam int P1 = (PLAYERS > 1) ? 1 : 0;

    // Key-state slots; the four direction slots line up with joy bits {U,D,L,R}
    localparam int K_START1  = 0;
    localparam int K_START2  = 1;
    localparam int K_COIN1   = 2;
    localparam int K_COIN2   = 3;
    localparam int K_SERVICE = 4;
    localparam int K_PAUSE   = 5;
    localparam int K_R       = 6;
    localparam int K_U       = 9;
    localparam int K_B0      = 10;

    logic                         key_tog_r;
    logic [13:0]                  key_state_r;
    logic [13:0]                  key_sel_s;
    logic                         key_event_s;

    logic [4*PLAYERS-1:0]         raw_dir_s;
    logic [BUTTONS*PLAYERS-1:0]   raw_btn_s;
    logic [PLAYERS-1:0]           raw_start_s;
    logic [PLAYERS-1:0]           raw_coin_s;

    logic [4*PLAYERS-1:0]         dir_act_s;
    logic [BUTTONS*PLAYERS-1:0]   btn_act_s;
    logic [PLAYERS-1:0]           coin_act_s;
    logic [PLAYERS-1:0]           af_rise_s;
    logic [PLAYERS-1:0]           af_gate_s;

    logic [CW-1:0]                coin_cnt_r      [PLAYERS];
    logic [CW-1:0]                coin_cnt_next_s [PLAYERS];
    logic [PW-1:0]                af_phase_r      [PLAYERS];
    logic [PW-1:0]                af_phase_next_s [PLAYERS];
    logic [PLAYERS-1:0]           coin_prev_r;
    logic [BUTTONS*PLAYERS-1:0]   btn_prev_r;

    logic                         pause_lvl_r;
    logic                         pause_prev_r;
    logic                         unused_s;

    assign key_event_s = (ps2_key[10] != key_tog_r);

    // Scancode to key-state slot decode (extended bit is deliberately not part of the match)
    always_comb begin
        key_sel_s = 14'd0;
        case (ps2_key[7:0])
            8'h16:   key_sel_s[K_START1]  = 1'b1;
            8'h1E:   key_sel_s[K_START2]  = 1'b1;
            8'h2E:   key_sel_s[K_COIN1]   = 1'b1;
            8'h36:   key_sel_s[K_COIN2]   = 1'b1;
            8'h46:   key_sel_s[K_SERVICE] = 1'b1;
            8'h4D:   key_sel_s[K_PAUSE]   = 1'b1;
            8'h74:   key_sel_s[6]         = 1'b1;
            8'h6B:   key_sel_s[7]         = 1'b1;
            8'h72:   key_sel_s[8]         = 1'b1;
            8'h75:   key_sel_s[9]         = 1'b1;
            8'h14:   key_sel_s[10]        = 1'b1;
            8'h11:   key_sel_s[11]        = 1'b1;
            8'h29:   key_sel_s[12]        = 1'b1;
            8'h12:   key_sel_s[13]        = 1'b1;
            default: key_sel_s = 14'd0;
        endcase
    end

    // Keyboard press/release latch, one update per toggle change
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            key_tog_r   <= 1'b0;
            key_state_r <= 14'd0;
        end else if (key_event_s) begin
            key_tog_r   <= ps2_key[10];
            key_state_r <= (key_state_r & ~key_sel_s) | (key_sel_s & {14{ps2_key[9]}});
        end
    end

    // Raw per-player levels: joystick OR keyboard (keyboard feeds player 0, start2/coin2 player 1)
    always_comb begin
        raw_dir_s   = {(4*PLAYERS){1'b0}};
        raw_btn_s   = {(BUTTONS*PLAYERS){1'b0}};
        raw_start_s = {PLAYERS{1'b0}};
        raw_coin_s  = {PLAYERS{1'b0}};
        for (int p = 0; p < PLAYERS; p++) begin
            raw_dir_s[4*p +: 4] = joy[16*p +: 4];
            for (int b = 0; b < BUTTONS; b++) begin
                raw_btn_s[BUTTONS*p + b] = joy[16*p + 4 + b];
            end
            raw_start_s[p] = joy[16*p + 4 + BUTTONS];
            raw_coin_s[p]  = joy[16*p + 5 + BUTTONS];
        end
        raw_dir_s[3:0] = raw_dir_s[3:0] | key_state_r[K_U:K_R];
        for (int b = 0; b < BUTTONS; b++) begin
            raw_btn_s[b] = raw_btn_s[b] | key_state_r[K_B0 + b];
        end
        raw_start_s[0]  = raw_start_s[0] | key_state_r[K_START1];
        raw_coin_s[0]   = raw_coin_s[0] | key_state_r[K_COIN1];
        raw_start_s[P1] = raw_start_s[P1] | (key_state_r[K_START2] & (PLAYERS > 1));
        raw_coin_s[P1]  = raw_coin_s[P1] | (key_state_r[K_COIN2] & (PLAYERS > 1));
    end

    // SOCD cleaning, coin stretch and autofire gating per player
    always_comb begin
        dir_act_s  = {(4*PLAYERS){1'b0}};
        btn_act_s  = {(BUTTONS*PLAYERS){1'b0}};
        coin_act_s = {PLAYERS{1'b0}};
        af_rise_s  = {PLAYERS{1'b0}};
        af_gate_s  = {PLAYERS{1'b0}};
        for (int p = 0; p < PLAYERS; p++) begin
            coin_cnt_next_s[p] = coin_cnt_r[p];
            af_phase_next_s[p] = af_phase_r[p];
        end
        for (int p = 0; p < PLAYERS; p++) begin
            // Output order is {down,up,right,left}; raw order is {U,D,L,R}
            if (SOCD_NEUTRAL != 0) begin
                dir_act_s[4*p + 3] = raw_dir_s[4*p + 2] & ~raw_dir_s[4*p + 3];
                dir_act_s[4*p + 2] = raw_dir_s[4*p + 3] & ~raw_dir_s[4*p + 2];
                dir_act_s[4*p + 1] = raw_dir_s[4*p + 0] & ~raw_dir_s[4*p + 1];
                dir_act_s[4*p + 0] = raw_dir_s[4*p + 1] & ~raw_dir_s[4*p + 0];
            end else begin
                dir_act_s[4*p + 3] = raw_dir_s[4*p + 2];
                dir_act_s[4*p + 2] = raw_dir_s[4*p + 3];
                dir_act_s[4*p + 1] = raw_dir_s[4*p + 0];
                dir_act_s[4*p + 0] = raw_dir_s[4*p + 1];
            end

            if (raw_coin_s[p] && !coin_prev_r[p] && (coin_cnt_r[p] == {CW{1'b0}})) begin
                coin_cnt_next_s[p] = COIN_LOAD;
            end else if (coin_cnt_r[p] != {CW{1'b0}}) begin
                coin_cnt_next_s[p] = coin_cnt_r[p] - CW'(1);
            end else begin
                coin_cnt_next_s[p] = coin_cnt_r[p];
            end
            coin_act_s[p] = raw_coin_s[p] | (coin_cnt_next_s[p] != {CW{1'b0}});

            // Restarting the phase on a fresh press makes the first half-period active
            af_rise_s[p] = |(raw_btn_s[BUTTONS*p +: BUTTONS] & ~btn_prev_r[BUTTONS*p +: BUTTONS] & af_en);
            if (af_rise_s[p]) begin
                af_phase_next_s[p] = {PW{1'b0}};
            end else begin
                af_phase_next_s[p] = af_phase_r[p] + PW'(1);
            end
            af_gate_s[p] = ~af_phase_next_s[p][AF_SHIFT + int'(af_rate)];
            for (int b = 0; b < BUTTONS; b++) begin
                btn_act_s[BUTTONS*p + b] = raw_btn_s[BUTTONS*p + b] & (~af_en[b] | af_gate_s[p]);
            end
        end
    end

    // Ignored input bits folded together so they are visibly consumed
    always_comb begin
        unused_s = ps2_key[8];
        for (int p = 0; p < PLAYERS; p++) begin
            for (int i = 6 + BUTTONS; i < 16; i++) begin
                unused_s = unused_s ^ joy[16*p + i];
            end
        end
        for (int b = BUTTONS; b < 4; b++) begin
            unused_s = unused_s ^ key_state_r[K_B0 + b];
        end
    end

    // Per-player counters and edge-detect history
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            coin_prev_r <= {PLAYERS{1'b0}};
            btn_prev_r  <= {(BUTTONS*PLAYERS){1'b0}};
            for (int p = 0; p < PLAYERS; p++) begin
                coin_cnt_r[p] <= {CW{1'b0}};
                af_phase_r[p] <= {PW{1'b0}};
            end
        end else begin
            coin_prev_r <= raw_coin_s;
            btn_prev_r  <= raw_btn_s;
            for (int p = 0; p < PLAYERS; p++) begin
                coin_cnt_r[p] <= coin_cnt_next_s[p];
                af_phase_r[p] <= af_phase_next_s[p];
            end
        end
    end

    // Registered active-low cabinet outputs and pause edge pulse
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            dir_n        <= {(4*PLAYERS){1'b1}};
            btn_n        <= {(BUTTONS*PLAYERS){1'b1}};
            start_n      <= {PLAYERS{1'b1}};
            coin_n       <= {PLAYERS{1'b1}};
            service_n    <= 1'b1;
            pause_lvl_r  <= 1'b0;
            pause_prev_r <= 1'b0;
            pause_pulse  <= 1'b0;
        end else begin
            dir_n        <= ~dir_act_s;
            btn_n        <= ~btn_act_s;
            start_n      <= ~raw_start_s;
            coin_n       <= ~coin_act_s;
            service_n    <= ~key_state_r[K_SERVICE];
            pause_lvl_r  <= key_state_r[K_PAUSE] | pause_in;
            pause_prev_r <= pause_lvl_r;
            pause_pulse  <= pause_lvl_r & ~pause_prev_r;
        end
    end

endmodule

// File: tb/tb_arcade_input_hub.sv
// Self-checking bench for arcade_input_hub: timestamp-based reference model plus directed
// scenarios, with a second wide instance (4 players, 4 buttons, SOCD pass-through).
module tb_arcade_input_hub;

    localparam int P   = 2;
    localparam int B   = 2;
    localparam int CC  = 20;
    localparam int AFS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] ps2_key;
    logic [31:0] joy;
    logic [63:0] joy4;
    logic        pause_in;
    logic [1:0]  af_en;
    logic [3:0]  af_en4;
    logic [1:0]  af_rate;

    logic [7:0]  dir_n;
    logic [3:0]  btn_n;
    logic [1:0]  start_n, coin_n;
    logic        service_n, pause_pulse;
    logic [15:0] dir_n4, btn_n4;
    logic [3:0]  start_n4, coin_n4;
    logic        service_n4, pause_pulse4;

    int checks = 0;
    int errors = 0;
    logic kt = 1'b0;

    always #5 clk = ~clk;

    arcade_input_hub #(.PLAYERS(P), .BUTTONS(B), .COIN_CYCLES(CC), .AF_SHIFT(AFS), .SOCD_NEUTRAL(1)) u_dut (
        .clk_49m(clk), .reset(rst_n), .ps2_key(ps2_key), .joy(joy), .pause_in(pause_in),
        .af_en(af_en), .af_rate(af_rate), .dir_n(dir_n), .btn_n(btn_n), .start_n(start_n),
        .coin_n(coin_n), .service_n(service_n), .pause_pulse(pause_pulse)
    );

    arcade_input_hub #(.PLAYERS(4), .BUTTONS(4), .COIN_CYCLES(12), .AF_SHIFT(3), .SOCD_NEUTRAL(0)) u_dut4 (
        .clk_49m(clk), .reset(rst_n), .ps2_key(ps2_key), .joy(joy4), .pause_in(pause_in),
        .af_en(af_en4), .af_rate(af_rate), .dir_n(dir_n4), .btn_n(btn_n4), .start_n(start_n4),
        .coin_n(coin_n4), .service_n(service_n4), .pause_pulse(pause_pulse4)
    );

    // Reference model: key map by scancode, timestamps for coin and autofire, level history for pause
    bit   m_key [256];
    bit   m_tog;
    int   cyc = 0;
    int   coin_t0 [P];
    bit   coin_prev [P];
    int   af_t0 [P];
    bit   btn_prev [P][B];
    bit   lvl1, lvl2;
    int   btn_code [4] = '{8'h14, 8'h11, 8'h29, 8'h12};
    int   dir_code [4] = '{8'h74, 8'h6B, 8'h72, 8'h75};
    logic [7:0] e_dir_n;
    logic [3:0] e_btn_n;
    logic [1:0] e_start_n, e_coin_n;
    logic       e_service_n, e_pause;

    always @(posedge clk or negedge rst_n) begin
        bit [3:0] rdir;
        bit up, dn, lf, rt, rb, rc, rise, act;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) m_key[i] = 1'b0;
            m_tog = 1'b0;
            lvl1 = 1'b0;
            lvl2 = 1'b0;
            for (int p = 0; p < P; p++) begin
                coin_t0[p] = -100000;
                coin_prev[p] = 1'b0;
                af_t0[p] = cyc;
                for (int b = 0; b < B; b++) btn_prev[p][b] = 1'b0;
            end
            e_dir_n = 8'hFF; e_btn_n = 4'hF; e_start_n = 2'b11; e_coin_n = 2'b11;
            e_service_n = 1'b1; e_pause = 1'b0;
        end else begin
            for (int p = 0; p < P; p++) begin
                for (int k = 0; k < 4; k++) rdir[k] = joy[16*p + k] | (p == 0 && m_key[dir_code[k]]);
                up = rdir[3] && !rdir[2];
                dn = rdir[2] && !rdir[3];
                lf = rdir[1] && !rdir[0];
                rt = rdir[0] && !rdir[1];
                e_dir_n[4*p +: 4] = ~{dn, up, rt, lf};
                rise = 1'b0;
                for (int b = 0; b < B; b++) begin
                    rb = joy[16*p + 4 + b] | (p == 0 && m_key[btn_code[b]]);
                    if (af_en[b] && rb && !btn_prev[p][b]) rise = 1'b1;
                end
                if (rise) af_t0[p] = cyc;
                for (int b = 0; b < B; b++) begin
                    rb = joy[16*p + 4 + b] | (p == 0 && m_key[btn_code[b]]);
                    act = rb && (!af_en[b] || (((cyc - af_t0[p]) >> (AFS + int'(af_rate))) % 2) == 0);
                    e_btn_n[B*p + b] = !act;
                    btn_prev[p][b] = rb;
                end
                rc = joy[16*p + 5 + B] | ((p == 0) ? m_key[8'h2E] : m_key[8'h36]);
                if (rc && !coin_prev[p] && (cyc - coin_t0[p]) > CC) coin_t0[p] = cyc;
                e_coin_n[p] = !(rc || (cyc - coin_t0[p]) < CC);
                coin_prev[p] = rc;
                e_start_n[p] = !(joy[16*p + 4 + B] | ((p == 0) ? m_key[8'h16] : m_key[8'h1E]));
            end
            e_service_n = !m_key[8'h46];
            e_pause = lvl1 && !lvl2;
            lvl2 = lvl1;
            lvl1 = m_key[8'h4D] | pause_in;
            if (ps2_key[10] != m_tog) begin
                m_key[ps2_key[7:0]] = ps2_key[9];
                m_tog = ps2_key[10];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("dir_n", dir_n, e_dir_n);
        chk("btn_n", btn_n, e_btn_n);
        chk("start_n", start_n, e_start_n);
        chk("coin_n", coin_n, e_coin_n);
        chk("service_n", service_n, e_service_n);
        chk("pause_pulse", pause_pulse, e_pause);
    endtask

    task automatic key(input logic [7:0] code, input logic pr);
        kt = ~kt;
        ps2_key = {kt, pr, 1'b0, code};
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_dir"}, dir_n, 8'hFF);
        chk({tag, "_btn"}, btn_n, 4'hF);
        chk({tag, "_start"}, start_n, 2'b11);
        chk({tag, "_coin"}, coin_n, 2'b11);
        chk({tag, "_svc"}, service_n, 1'b1);
        chk({tag, "_pause"}, pause_pulse, 1'b0);
        chk({tag, "_dir4"}, dir_n4, 16'hFFFF);
        chk({tag, "_btn4"}, btn_n4, 16'hFFFF);
        chk({tag, "_start4"}, start_n4, 4'hF);
        chk({tag, "_coin4"}, coin_n4, 4'hF);
        chk({tag, "_svc4"}, service_n4, 1'b1);
        chk({tag, "_pause4"}, pause_pulse4, 1'b0);
    endtask

    initial begin
        int cnt;
        logic [7:0] codes [16] = '{8'h16, 8'h1E, 8'h2E, 8'h36, 8'h46, 8'h4D, 8'h75, 8'h72,
                                   8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12, 8'h5A, 8'h00};
        rst_n = 1'b0; ps2_key = 11'd0; joy = 32'd0; joy4 = 64'd0; pause_in = 1'b0;
        af_en = 2'b00; af_en4 = 4'b0000; af_rate = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_idle("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Keyboard coin: 2-clk latency, stretched to exactly CC cycles, re-press ignored
        key(8'h2E, 1'b1);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 0) chk("coin_lat1", coin_n[0], 1'b1);
            if (i == 1) chk("coin_lat2", coin_n[0], 1'b0);
            if (coin_n[0] == 1'b0) cnt++;
            if (i == 2) key(8'h2E, 1'b0);
            if (i == 7) key(8'h2E, 1'b1);
            if (i == 10) key(8'h2E, 1'b0);
        end
        chk("coin_width", cnt, CC);

        // SOCD: neutral on main instance, pass-through on the wide one
        joy[3:0] = 4'hF; joy4[3:0] = 4'hF;
        tick();
        chk("socd_n_all", dir_n[3:0], 4'hF);
        chk("socd_p_all", dir_n4[3:0], 4'h0);
        joy[3:0] = 4'b1001; joy4[3:0] = 4'b1001;
        tick();
        chk("socd_n_ur", dir_n[3:0], 4'b1001);
        chk("socd_p_ur", dir_n4[3:0], 4'b1001);
        joy = 32'd0; joy4 = 64'd0;
        tick();

        // Autofire on player 1 button 0: 16 low / 16 high, first low after 1 clk
        af_en = 2'b01; af_rate = 2'b00;
        joy[20] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("af_phase", btn_n[2], ((i / 16) % 2 == 0) ? 1'b0 : 1'b1);
        end
        joy[20] = 1'b0;
        tick();

        // Pause: one pulse per rising edge of the combined level
        pause_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (pause_pulse) cnt++; end
        chk("pause_held", cnt, 1);
        key(8'h4D, 1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (pause_pulse) cnt++; end
        pause_in = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (pause_pulse) cnt++; end
        key(8'h4D, 1'b0);
        for (int i = 0; i < 10; i++) begin tick(); if (pause_pulse) cnt++; end
        chk("pause_none", cnt, 0);
        key(8'h4D, 1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (pause_pulse) cnt++; end
        chk("pause_key", cnt, 1);
        key(8'h4D, 1'b0);
        repeat (3) tick();

        // Wide instance: button 3 key and player 3 joystick coin
        key(8'h12, 1'b1);
        tick();
        chk("btn3_lat1", btn_n4[3], 1'b1);
        tick();
        chk("btn3_lat2", btn_n4[3], 1'b0);
        key(8'h12, 1'b0);
        joy4[57] = 1'b1;
        tick();
        chk("coin4_p3", coin_n4[3], 1'b0);
        joy4 = 64'd0;
        repeat (30) tick();

        // Async reset mid coin stretch and autofire
        af_en = 2'b11;
        joy[4] = 1'b1; joy[7] = 1'b1;
        repeat (3) tick();
        joy[7] = 1'b0;
        repeat (2) tick();
        chk("pre_rst_coin", coin_n[0], 1'b0);
        chk("pre_rst_btn", btn_n[0], 1'b0);
        #2;
        rst_n = 1'b0; joy = 32'd0; pause_in = 1'b0;
        kt = 1'b1; ps2_key = {1'b1, 1'b1, 1'b0, 8'h46};
        #1;
        chk_all_idle("async_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("svc_lat1", service_n, 1'b1);
        tick();
        chk("svc_first_evt", service_n, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("coin_idle", coin_n, 2'b11);
        end
        key(8'h46, 1'b0);
        repeat (3) tick();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            int idx;
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, 31);
                joy[idx] = ~joy[idx];
            end
            if ($urandom_range(0, 9) == 0) begin
                kt = ~kt;
                ps2_key = {kt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
            end
            if ($urandom_range(0, 29) == 0) pause_in = ~pause_in;
            if ($urandom_range(0, 99) == 0) af_en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) af_rate = 2'($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
